uart_rx_sequencer: RTL and testbench

Receive-side sequencer for the UART: detects a start bit on the serial line, gates the oversampling baud tick, samples each bit at mid-bit, assembles the frame, and hands complete bytes to the consumer over a valid/ready handshake. It sits between the baud/tick generator and the host-side register interface, and reports framing errors and overruns.

---
 rtl/uart_rx_sequencer_if.sv | 12 +
 rtl/uart_rx_sequencer.sv | 148 ++++++++++++++
 tb/tb_uart_rx_sequencer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_sequencer_if.sv
// Byte hand-off from the UART receive sequencer to its consumer.
// The receiver drives data/valid; the consumer answers with ready.
interface uart_rx_sequencer_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: start detect, mid-bit sampling, frame assembly,
// valid/ready byte hand-off with framing-error and overrun reporting.
module uart_rx_sequencer #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx,
  input  logic                 i_tick,
  input  logic                 i_clr,
  output logic                 o_bauden,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy,
  uart_rx_sequencer_if.master  host
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

  localparam logic [TickW-1:0] HalfTick = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] FullTick = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  LastBit  = BitW'(DATA_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StLoad} state_e;

  state_e               state_q;
  logic                 sync_q, rx_s_q, rx_prev_q;
  logic [TickW-1:0]     tick_cnt_q;
  logic [BitW-1:0]      bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 bauden_q, busy_q, frame_err_q, overrun_q;

  logic tick_go, fall;

  // Ticks are only meaningful while the generator is enabled.
  assign tick_go = i_tick & bauden_q;
  assign fall    = rx_prev_q & ~rx_s_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      sync_q      <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      bauden_q    <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= i_rx;
      rx_s_q      <= sync_q;
      rx_prev_q   <= rx_s_q;
      frame_err_q <= 1'b0;

      if (i_clr) overrun_q <= 1'b0;
      if (valid_q && host.ready) valid_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (fall) begin
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            state_q    <= StStart;
            bauden_q   <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        StStart: begin
          if (tick_go) begin
            if (tick_cnt_q == HalfTick) begin
              if (rx_s_q) begin
                state_q  <= StIdle;
                bauden_q <= 1'b0;
                busy_q   <= 1'b0;
              end else begin
                tick_cnt_q <= '0;
                state_q    <= StData;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
        StData: begin
          if (tick_go) begin
            if (tick_cnt_q == FullTick) begin
              shift_q    <= {rx_s_q, shift_q[DATA_BITS-1:1]};
              bit_cnt_q  <= bit_cnt_q + 1'b1;
              tick_cnt_q <= '0;
              if (bit_cnt_q == LastBit) state_q <= StStop;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
        StStop: begin
          if (tick_go) begin
            if (tick_cnt_q == FullTick) begin
              bauden_q <= 1'b0;
              if (rx_s_q) begin
                state_q <= StLoad;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= StIdle;
                busy_q      <= 1'b0;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
        StLoad: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          // A byte still pending and not taken this cycle is kept; the new one is dropped.
          if (!valid_q || host.ready) begin
            data_q  <= shift_q;
            valid_q <= 1'b1;
          end else begin
            overrun_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= StIdle;
          bauden_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_bauden    = bauden_q;
  assign o_busy      = busy_q;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;
  assign host.data   = data_q;
  assign host.valid  = valid_q;

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Bench for uart_rx_sequencer: directed scenarios plus random frames checked
// against a byte-level model of the receive/hand-off rules.
module tb_uart_rx_sequencer;

  localparam int DB     = 8;
  localparam int OS     = 16;
  localparam int TDIV   = 4;
  localparam int BITCLK = OS * TDIV;

  logic clk, rst, i_rx, i_tick, i_clr;
  logic o_bauden, o_frame_err, o_overrun, o_busy;

  int checks, errors;
  int fe_pulses, fe_cycles;
  logic fe_prev;

  // Byte-level model state
  logic [7:0] m_data;
  logic       m_valid, m_ov;
  int         m_fe;

  uart_rx_sequencer_if #(.DATA_BITS(DB)) host ();

  uart_rx_sequencer #(
    .DATA_BITS (DB),
    .OVERSAMPLE(OS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_rx       (i_rx),
    .i_tick     (i_tick),
    .i_clr      (i_clr),
    .o_bauden   (o_bauden),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun),
    .o_busy     (o_busy),
    .host       (host)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tick generator: one tick every TDIV clocks while enabled.
  initial begin
    int div;
    div    = 0;
    i_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!o_bauden) begin
        div    = 0;
        i_tick = 1'b0;
      end else begin
        div++;
        i_tick = (div % TDIV == 0);
      end
    end
  end

  // Frame-error pulse monitor: counts pulses and high cycles.
  initial begin
    fe_pulses = 0;
    fe_cycles = 0;
    fe_prev   = 1'b0;
    forever begin
      @(negedge clk);
      if (o_frame_err === 1'b1) begin
        fe_cycles++;
        if (!fe_prev) fe_pulses++;
      end
      fe_prev = (o_frame_err === 1'b1);
    end
  end

  task automatic clks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input bit probe);
    i_rx = 1'b0;
    if (probe) begin
      clks(2);
      chk("start_not_yet", 32'(o_busy), 32'd0);
      clks(1);
      chk("start_at_3", 32'(o_busy), 32'd1);
      clks(BITCLK - 3);
    end else begin
      clks(BITCLK);
    end
    for (int i = 0; i < DB; i++) begin
      i_rx = d[i];
      clks(BITCLK);
    end
    i_rx = stop_ok;
    clks(BITCLK);
    i_rx = 1'b1;
    clks(8);
  endtask

  task automatic model_frame(input logic [7:0] d, input logic ok, input bit ready_at_load);
    if (!ok) m_fe++;
    else if (m_valid && !ready_at_load) m_ov = 1'b1;
    else begin
      m_data  = d;
      m_valid = 1'b1;
    end
  endtask

  task automatic pulse_ready();
    host.ready = 1'b1;
    clks(1);
    host.ready = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    i_clr = 1'b1;
    clks(1);
    i_clr = 1'b0;
    m_ov = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data"}, 32'(host.data), 32'(m_data));
    chk({tag, ".valid"}, 32'(host.valid), 32'(m_valid));
    chk({tag, ".overrun"}, 32'(o_overrun), 32'(m_ov));
    chk({tag, ".fe_pulses"}, 32'(fe_pulses), 32'(m_fe));
    chk({tag, ".fe_width"}, 32'(fe_cycles), 32'(m_fe));
  endtask

  initial begin
    bit found;
    logic [7:0] rd;
    logic rok;
    int   ract;

    checks     = 0;
    errors     = 0;
    m_data     = '0;
    m_valid    = 1'b0;
    m_ov       = 1'b0;
    m_fe       = 0;
    rst        = 1'b0;
    i_rx       = 1'b1;
    i_clr      = 1'b0;
    host.ready = 1'b0;

    clks(3);
    chk("rst.bauden", 32'(o_bauden), 32'd0);
    chk("rst.busy", 32'(o_busy), 32'd0);
    chk("rst.frame_err", 32'(o_frame_err), 32'd0);
    check_all("rst");
    rst = 1'b1;
    clks(5);

    // Good frame, held until consumed
    send_frame(8'hA5, 1'b1, 1'b1);
    model_frame(8'hA5, 1'b1, 1'b0);
    check_all("a5");
    clks(20);
    chk("a5.hold_valid", 32'(host.valid), 32'd1);
    pulse_ready();
    check_all("a5.taken");

    // Short low glitch: false start
    i_rx = 1'b0;
    clks(10);
    chk("glitch.bauden_on", 32'(o_bauden), 32'd1);
    clks(10);
    i_rx = 1'b1;
    clks(60);
    chk("glitch.bauden_off", 32'(o_bauden), 32'd0);
    chk("glitch.idle", 32'(o_busy), 32'd0);
    check_all("glitch");

    // Bad stop bit
    send_frame(8'h3C, 1'b0, 1'b0);
    model_frame(8'h3C, 1'b0, 1'b0);
    check_all("ferr");

    // Overrun
    send_frame(8'h11, 1'b1, 1'b0);
    model_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    model_frame(8'h22, 1'b1, 1'b0);
    check_all("ovr");
    pulse_ready();
    check_all("ovr.taken");
    pulse_clr();
    check_all("ovr.clr");

    // Back-to-back with ready coincident with the second load
    send_frame(8'h55, 1'b1, 1'b0);
    model_frame(8'h55, 1'b1, 1'b0);
    found = 1'b0;
    fork
      send_frame(8'hAA, 1'b1, 1'b0);
      begin
        for (int k = 0; k < 2000 && !found; k++) begin
          clks(1);
          if (o_busy && !o_bauden) found = 1'b1;
        end
        if (found) begin
          host.ready = 1'b1;
          clks(1);
          host.ready = 1'b0;
        end
      end
    join
    chk("b2b.load_seen", 32'(found), 32'd1);
    model_frame(8'hAA, 1'b1, 1'b1);
    check_all("b2b");
    pulse_ready();

    // Reset during data bit 4
    i_rx = 1'b0;
    clks(BITCLK);
    i_rx = 1'b1;
    clks(4 * BITCLK + BITCLK / 2);
    rst = 1'b0;
    #2;
    m_data  = '0;
    m_valid = 1'b0;
    m_ov    = 1'b0;
    chk("midrst.bauden", 32'(o_bauden), 32'd0);
    chk("midrst.busy", 32'(o_busy), 32'd0);
    check_all("midrst");
    clks(2);
    rst = 1'b1;
    clks(4 * BITCLK);
    chk("midrst.idle", 32'(o_busy), 32'd0);
    send_frame(8'h81, 1'b1, 1'b0);
    model_frame(8'h81, 1'b1, 1'b0);
    check_all("after_rst");

    // Random frames
    for (int n = 0; n < 12; n++) begin
      rd   = 8'($urandom);
      rok  = ($urandom_range(0, 4) != 0);
      send_frame(rd, rok, 1'b0);
      model_frame(rd, rok, 1'b0);
      check_all($sformatf("rnd%0d", n));
      ract = $urandom_range(0, 2);
      if (ract == 0) pulse_ready();
      else if (ract == 1) pulse_clr();
      check_all($sformatf("rnd%0d.post", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
